// File: rtl/bank_accounter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bank_accounter : per-address record of which write bank last wrote it,
//                  plus optional multi-writer collision flag. Rev 1.0
// ---------------------------------------------------------------------------
module bank_accounter #(
  parameter  int ADDR_WIDTH      = 3,
  parameter  int NB_WRAGENT      = 2,
  parameter  int NB_RDAGENT      = 2,
  parameter  int WRITE_COLLISION = 1,
  localparam int BANK_W          = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT),
  localparam int SELECT_WIDTH    = BANK_W + WRITE_COLLISION
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [NB_WRAGENT-1:0]              m_wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
  input  logic [NB_RDAGENT-1:0]              m_rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] bank_select,
  output logic [NB_WRAGENT-1:0]              m_wrcollision
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [SELECT_WIDTH-1:0] entries   [DEPTH];
  logic [SELECT_WIDTH-1:0] new_entry [DEPTH];
  logic [BANK_W-1:0]       hi_bank   [DEPTH];
  logic [DEPTH-1:0]        hit;
  logic [DEPTH-1:0]        multi;
  logic [NB_WRAGENT-1:0]   coll_d;
  logic [NB_WRAGENT-1:0]   coll_q;

  // The read side registers bank_select itself; the enable is not needed here.
  logic unused_rden;
  assign unused_rden = ^m_rden;

  // Ascending agent scan leaves the highest writing agent in hi_bank.
  always_comb begin
    hit    = '0;
    multi  = '0;
    coll_d = '0;
    for (int a = 0; a < DEPTH; a++) begin
      hi_bank[a] = '0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (m_wren[i] && (m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(a))) begin
          multi[a]   = multi[a] | hit[a];
          hit[a]     = 1'b1;
          hi_bank[a] = BANK_W'(i);
        end
      end
    end
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if ((i != j) && m_wren[i] && m_wren[j] &&
            (m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == m_wraddr[j*ADDR_WIDTH +: ADDR_WIDTH]))
          coll_d[i] = 1'b1;
      end
    end
  end

  generate
    if (WRITE_COLLISION != 0) begin : g_flag
      for (genvar a = 0; a < DEPTH; a++) begin : g_entry
        assign new_entry[a] = {multi[a], hi_bank[a]};
      end
      assign m_wrcollision = coll_q;
    end else begin : g_noflag
      for (genvar a = 0; a < DEPTH; a++) begin : g_entry
        assign new_entry[a] = hi_bank[a];
      end
      assign m_wrcollision = '0;
      logic unused_coll;
      assign unused_coll = ^{multi, coll_q};
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int a = 0; a < DEPTH; a++) entries[a] <= '0;
      coll_q <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (hit[a]) entries[a] <= new_entry[a];
      end
      coll_q <= coll_d;
    end
  end

  // Read-first: combinational lookup of the pre-edge table contents.
  generate
    for (genvar j = 0; j < NB_RDAGENT; j++) begin : g_rd
      assign bank_select[j*SELECT_WIDTH +: SELECT_WIDTH] =
        aresetn ? entries[m_rdaddr[j*ADDR_WIDTH +: ADDR_WIDTH]] : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bank_accounter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bank_accounter : directed + randomized checks against a table model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bank_accounter;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic [1:0] wren;
  logic [5:0] wraddr;
  logic [1:0] rden;
  logic [5:0] rdaddr;
  logic [3:0] bsel;
  logic [1:0] wcol;

  logic [3:0]  wren4;
  logic [11:0] wraddr4;
  logic [1:0]  rden4;
  logic [5:0]  rdaddr4;
  logic [3:0]  bsel4;
  logic [3:0]  wcol4;

  always #5 aclk = ~aclk;

  bank_accounter dut (
    .aclk(aclk), .aresetn(aresetn), .m_wren(wren), .m_wraddr(wraddr),
    .m_rden(rden), .m_rdaddr(rdaddr), .bank_select(bsel), .m_wrcollision(wcol)
  );

  bank_accounter #(.ADDR_WIDTH(3), .NB_WRAGENT(4), .NB_RDAGENT(2), .WRITE_COLLISION(0)) dut4 (
    .aclk(aclk), .aresetn(aresetn), .m_wren(wren4), .m_wraddr(wraddr4),
    .m_rden(rden4), .m_rdaddr(rdaddr4), .bank_select(bsel4), .m_wrcollision(wcol4)
  );

  // Reference model: last writer and collision flag per address.
  int         m_bank [8];
  int         m_flag [8];
  logic [1:0] m_coll;
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 8; a++) begin
      m_bank[a] = 0;
      m_flag[a] = 0;
    end
    m_coll = 2'b00;
  endtask

  // Inputs are already driven; compare outputs against the model.
  task automatic settle_check(input string tag);
    logic [1:0] exp;
    int a;
    #1;
    for (int j = 0; j < 2; j++) begin
      a   = int'(rdaddr[j*3 +: 3]);
      exp = aresetn ? {m_flag[a][0], m_bank[a][0]} : 2'b00;
      chk($sformatf("%s_rd%0d", tag, j), {6'd0, bsel[j*2 +: 2]}, {6'd0, exp});
    end
    chk($sformatf("%s_coll", tag), {6'd0, wcol}, {6'd0, aresetn ? m_coll : 2'b00});
  endtask

  task automatic tick();
    int cnt;
    int hi;
    logic [1:0] nc;
    @(posedge aclk);
    if (!aresetn) begin
      model_clear();
    end else begin
      nc = 2'b00;
      for (int a = 0; a < 8; a++) begin
        cnt = 0;
        hi  = 0;
        for (int i = 0; i < 2; i++) begin
          if (wren[i] && int'(wraddr[i*3 +: 3]) == a) begin
            cnt++;
            hi = i;
          end
        end
        if (cnt > 0) begin
          m_bank[a] = hi;
          m_flag[a] = (cnt >= 2) ? 1 : 0;
        end
        for (int i = 0; i < 2; i++)
          if (wren[i] && int'(wraddr[i*3 +: 3]) == a && cnt >= 2) nc[i] = 1'b1;
      end
      m_coll = nc;
    end
    @(negedge aclk);
  endtask

  task automatic drive(input logic [1:0] we, input logic [2:0] wa0, input logic [2:0] wa1,
                       input logic [2:0] ra0, input logic [2:0] ra1);
    wren   = we;
    wraddr = {wa1, wa0};
    rden   = 2'b11;
    rdaddr = {ra1, ra0};
  endtask

  initial begin
    aresetn = 1'b0;
    drive(2'b00, 3'd0, 3'd0, 3'd6, 3'd1);
    wren4 = '0; wraddr4 = '0; rden4 = '0; rdaddr4 = '0;
    model_clear();
    @(negedge aclk);
    // Reset state, with a write present that must be dropped
    drive(2'b11, 3'd6, 3'd1, 3'd6, 3'd1);
    settle_check("reset");
    tick();
    drive(2'b00, 3'd0, 3'd0, 3'd6, 3'd1);
    aresetn = 1'b1;
    settle_check("post_reset");
    tick();

    // Agent1 writes address 5
    drive(2'b10, 3'd0, 3'd5, 3'd5, 3'd5);
    settle_check("w5");
    tick();
    drive(2'b00, 3'd0, 3'd0, 3'd5, 3'd5);
    settle_check("r5");
    chk("r5_const", {4'd0, bsel}, 8'h05);
    chk("r5_coll_const", {6'd0, wcol}, 8'h00);
    tick();

    // Agents 0 and 1 collide on address 3
    drive(2'b11, 3'd3, 3'd3, 3'd3, 3'd0);
    settle_check("w3c");
    tick();
    drive(2'b00, 3'd0, 3'd0, 3'd3, 3'd3);
    settle_check("r3c");
    chk("r3c_const", {4'd0, bsel}, 8'h0F);
    chk("r3c_coll_const", {6'd0, wcol}, 8'h03);
    tick();
    settle_check("r3c_after");
    chk("r3c_coll_gone", {6'd0, wcol}, 8'h00);

    // Agent0 alone rewrites address 3, clearing the flag
    drive(2'b01, 3'd3, 3'd7, 3'd3, 3'd3);
    tick();
    drive(2'b00, 3'd0, 3'd0, 3'd3, 3'd3);
    settle_check("r3s");
    chk("r3s_const", {4'd0, bsel}, 8'h00);
    tick();

    // Read-first on address 2
    drive(2'b10, 3'd0, 3'd2, 3'd0, 3'd2);
    settle_check("rf_same");
    chk("rf_same_const", {6'd0, bsel[3:2]}, 8'h00);
    tick();
    drive(2'b00, 3'd0, 3'd0, 3'd0, 3'd2);
    settle_check("rf_next");
    chk("rf_next_const", {6'd0, bsel[3:2]}, 8'h01);
    tick();

    // Randomized traffic, small address space to provoke collisions
    for (int n = 0; n < 300; n++) begin
      drive(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      rden = 2'($urandom);
      settle_check("rand");
      tick();
    end

    // Populate 0..7 alternately, reset asserted mid-sequence
    for (int k = 0; k < 8; k++) begin
      drive((k % 2 == 0) ? 2'b01 : 2'b10, 3'(k), 3'(k), 3'(k), 3'(7 - k));
      if (k == 4) begin
        aresetn = 1'b0;
        #1;
        model_clear();
      end
      settle_check("pop");
      tick();
      if (k == 4) begin
        wren    = 2'b00;
        aresetn = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      drive(2'b00, 3'd0, 3'd0, 3'(k), 3'(k));
      settle_check("pop_rd");
      if (k <= 4) chk($sformatf("pop_rd_zero%0d", k), {4'd0, bsel}, 8'h00);
      tick();
    end

    // Four write agents, no collision tracking
    wren4   = 4'b1101;
    wraddr4 = {3'd7, 3'd7, 3'd7, 3'd7};
    @(posedge aclk);
    @(negedge aclk);
    wren4   = 4'b0000;
    rdaddr4 = {3'd7, 3'd7};
    #1;
    chk("w4_bank", {4'd0, bsel4}, 8'h0F);
    chk("w4_coll", {4'd0, wcol4}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bank_accounter.md
BANK_ACCOUNTER -- requirements
Module: bank_accounter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, meaning write/read address width and table depth 2**ADDR_WIDTH.
REQ-002 SHALL have parameter NB_WRAGENT, default 2, meaning number of write agents (= banks), legal range 1..4.
REQ-003 SHALL have parameter NB_RDAGENT, default 2, meaning number of read agents, legal range 1..4.
REQ-004 SHALL have parameter WRITE_COLLISION, default 1, meaning the write collision flag is tracked (1) or not (0).
REQ-005 SHALL define BANK_W = 1 when NB_WRAGENT==1, else clog2(NB_WRAGENT); SELECT_WIDTH = BANK_W + WRITE_COLLISION.
REQ-006 SHALL have port aclk  input  1  clock, all state on rising edge.
REQ-007 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port m_wren  input  NB_WRAGENT  per-agent write enable.
REQ-009 SHALL have port m_wraddr  input  NB_WRAGENT*ADDR_WIDTH  per-agent write address, agent i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL have port m_rden  input  NB_RDAGENT  per-agent read enable.
REQ-011 SHALL have port m_rdaddr  input  NB_RDAGENT*ADDR_WIDTH  per-agent read address.
REQ-012 SHALL have port bank_select  output  NB_RDAGENT*SELECT_WIDTH  per-read-agent bank index (LSBs) plus write collision flag (MSB, only when WRITE_COLLISION=1).
REQ-013 SHALL have port m_wrcollision  output  NB_WRAGENT  per-write-agent registered pulse: agent's write collided on its address last cycle.

Function
REQ-014 SHALL hold a table of 2**ADDR_WIDTH entries, each entry = {flag (if WRITE_COLLISION), bank index BANK_W bits}.
REQ-015 SHALL, per address A at each rising edge, determine the set of write agents with m_wren=1 and m_wraddr=A; empty set -> entry unchanged.
REQ-016 SHALL, for a non-empty set, store bank index = highest agent id in the set.
REQ-017 SHALL, when WRITE_COLLISION=1, store flag = 1 if set size >= 2, else 0 (a later single write to A clears the flag).
REQ-018 SHALL support writes by all NB_WRAGENT agents to distinct addresses in the same cycle, all entries updated on the same edge.
REQ-019 SHALL drive bank_select combinationally: slice j = table[m_rdaddr slice j], independent of m_rden (latency 0; read switch registers it).
REQ-020 SHALL be read-first: a read of address A in the same cycle as a write to A returns the entry value before that edge; new value visible from the next cycle.
REQ-021 SHALL allow any number of read agents to read the same address in the same cycle, each receiving the same entry value.
REQ-022 SHALL, when WRITE_COLLISION=1, assert m_wrcollision[i] for exactly one cycle after an edge where agent i wrote address A together with at least one other agent; agents writing alone -> 0.
REQ-023 SHALL tie m_wrcollision to 0 and omit flag storage when WRITE_COLLISION=0.
REQ-024 SHALL, for an address never written since reset, return bank index 0 and flag 0.
REQ-025 SHALL ignore m_wraddr when the matching m_wren=0 (no update, no collision contribution).

Reset
REQ-026 SHALL, on aresetn low (asynchronous), clear every table entry to 0 and m_wrcollision to 0.
REQ-027 SHALL, while aresetn is low, drive bank_select = 0 for all read agents regardless of m_rdaddr.
REQ-028 SHALL drop any write occurring in the cycle reset is asserted; first update happens on the first rising edge with aresetn high.

Verification
REQ-029 SHALL cover: defaults, agent1 writes addr 5, next cycle reader0 reads addr 5 -> bank_select[1:0] = 2'b01 (flag 0, bank 1); m_wrcollision = 2'b00.
REQ-030 SHALL cover: agents 0 and 1 both write addr 3 same cycle -> next cycle read addr 3 gives 2'b11 (flag 1, bank 1); m_wrcollision = 2'b11 for one cycle only.
REQ-031 SHALL cover: after REQ-030, agent0 alone writes addr 3 -> read addr 3 gives 2'b00; flag cleared.
REQ-032 SHALL cover: agent1 writes addr 2 while reader1 reads addr 2 same cycle -> same-cycle bank_select[3:2] = prior value 2'b00, following cycle 2'b01.
REQ-033 SHALL cover: populate addr 0..7 alternately by agents 0/1, assert aresetn low mid-sequence -> all reads return 0, m_wrcollision = 0, writes in the reset cycle lost.
REQ-034 SHALL cover: NB_WRAGENT=4, WRITE_COLLISION=0, agents 0,2,3 write addr 7 same cycle -> read addr 7 gives 2'b11 (SELECT_WIDTH=2), m_wrcollision = 4'b0000.
